// File: rtl/keypoint_window_gen.sv
// Streaming 3x3 window generator feeding the keypoint filter.
// Two line buffers plus per-row column taps build one window per interior pixel.
module keypoint_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pixel_in,
    input  logic               pixel_valid,
    input  logic               frame_start,
    output logic [23:0]        filter_input_0,
    output logic [23:0]        filter_input_1,
    output logic [23:0]        filter_input_2,
    output logic               window_valid,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic               frame_done
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];

    // Each tap pair holds {x-1, x-2} of its row; the incoming pixel is x.
    logic [15:0] sh0;
    logic [15:0] sh1;
    logic [15:0] sh2;

    logic               restart;
    logic               acc;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [AW-1:0]      ix;
    logic [7:0]         up2;
    logic [7:0]         up1;

    always_comb begin
        restart = pixel_valid && frame_start;
        acc     = pixel_valid && (frame_start || state == STREAM);
        x       = restart ? '0 : col;
        y       = restart ? '0 : row;
        ix      = x[AW-1:0];
        up2     = lb0[ix];
        up1     = lb1[ix];
    end

    // Buffer contents are never cleared; the row gate keeps stale data out.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[ix] <= lb1[ix];
            lb1[ix] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            sh0            <= '0;
            sh1            <= '0;
            sh2            <= '0;
            filter_input_0 <= '0;
            filter_input_1 <= '0;
            filter_input_2 <= '0;
            window_valid   <= 1'b0;
            center_x       <= '0;
            center_y       <= '0;
            frame_done     <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (acc) begin
                sh0 <= {up2, sh0[15:8]};
                sh1 <= {up1, sh1[15:8]};
                sh2 <= {pixel_in, sh2[15:8]};
                if (x >= TWO && y >= TWO) begin
                    window_valid   <= 1'b1;
                    filter_input_0 <= {up2, sh0};
                    filter_input_1 <= {up1, sh1};
                    filter_input_2 <= {pixel_in, sh2};
                    center_x       <= x - ONE;
                    center_y       <= y - ONE;
                end
                if (x == LAST_X) begin
                    col <= '0;
                    if (y == LAST_Y) begin
                        row        <= '0;
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        row   <= y + ONE;
                        state <= STREAM;
                    end
                end else begin
                    col   <= x + ONE;
                    row   <= y;
                    state <= STREAM;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypoint_window_gen.sv
// Directed bench for keypoint_window_gen on an 8x6 image.
// A monitor checks every window against the pixel pattern.
module tb_keypoint_window_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 10;

    typedef struct packed {
        logic [CW-1:0] cx;
        logic [CW-1:0] cy;
        logic [71:0]   rows;
    } win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [23:0]   filter_input_0;
    logic [23:0]   filter_input_1;
    logic [23:0]   filter_input_2;
    logic          window_valid;
    logic [CW-1:0] center_x;
    logic [CW-1:0] center_y;
    logic          frame_done;

    int   total = 0;
    int   bad   = 0;
    int   dcnt  = 0;
    int   pmode = 0;
    win_t q[$];

    keypoint_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COORD_W   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .frame_start   (frame_start),
        .filter_input_0(filter_input_0),
        .filter_input_1(filter_input_1),
        .filter_input_2(filter_input_2),
        .window_valid  (window_valid),
        .center_x      (center_x),
        .center_y      (center_y),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pv(int x, int y, int m);
        logic [7:0] v;
        v = 8'(y * 16 + x);
        return (m != 0) ? 8'hFF - v : v;
    endfunction

    // Outputs sampled 1 time unit after each edge; inputs change at +2.
    always @(posedge clk) begin
        #1;
        if (!rst && !pixel_valid) begin
            total++;
            assert (window_valid === 1'b0) else begin
                bad++;
                $error("FAIL gap_wv observed=%b expected=0", window_valid);
            end
        end
        if (window_valid === 1'b1) begin
            logic [71:0] exp;
            int cx;
            int cy;
            cx = int'(center_x);
            cy = int'(center_y);
            exp = {pv(cx+1, cy-1, pmode), pv(cx, cy-1, pmode),
                   pv(cx-1, cy-1, pmode),
                   pv(cx+1, cy, pmode), pv(cx, cy, pmode),
                   pv(cx-1, cy, pmode),
                   pv(cx+1, cy+1, pmode), pv(cx, cy+1, pmode),
                   pv(cx-1, cy+1, pmode)};
            q.push_back('{center_x, center_y,
                          {filter_input_0, filter_input_1, filter_input_2}});
            total++;
            assert ({filter_input_0, filter_input_1, filter_input_2} === exp)
            else begin
                bad++;
                $error("FAIL win(%0d,%0d) observed=%h expected=%h", cx, cy,
                       {filter_input_0, filter_input_1, filter_input_2}, exp);
            end
        end
        if (frame_done === 1'b1) begin
            dcnt++;
            total++;
            assert ({window_valid, center_x, center_y} ===
                    {1'b1, CW'(W-2), CW'(H-2)}) else begin
                bad++;
                $error("FAIL done_align observed=%b/%0d/%0d expected=1/%0d/%0d",
                       window_valid, center_x, center_y, W-2, H-2);
            end
        end
    end

    task automatic step(input logic v, input logic fs, input logic [7:0] p);
        pixel_valid = v;
        frame_start = fs;
        pixel_in    = p;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_px(input int x, input int y, input int m,
                           input logic fs);
        step(1'b1, fs, pv(x, y, m));
    endtask

    task automatic send_frame(input int m, input bit gap);
        pmode = m;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send_px(x, y, m, (x == 0 && y == 0));
                if (gap) step(1'b0, 1'b0, 8'h00);
            end
    endtask

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q.delete();
        dcnt = 0;
    endtask

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_first"}, 96'({q[base].cx, q[base].cy, q[base].rows}),
            96'({CW'(1), CW'(1), 72'h020100_121110_222120}));
        chk({tag, "_last"},
            96'({q[base+23].cx, q[base+23].cy, q[base+23].rows}),
            96'({CW'(6), CW'(4), 72'h373635_474645_575655}));
    endtask

    initial begin
        idle(2);
        chk("reset_outputs",
            96'({filter_input_0, filter_input_1, filter_input_2,
                 window_valid, center_x, center_y, frame_done}), 96'd0);
        rst = 1'b0;
        idle(2);

        clr();
        send_frame(0, 1'b0);
        idle(3);
        chk("full_count", 96'(q.size()), 96'd24);
        chk("full_done", 96'(dcnt), 96'd1);
        if (q.size() == 24) chk_frame("full", 0);

        clr();
        send_frame(0, 1'b1);
        idle(3);
        chk("gap_count", 96'(q.size()), 96'd24);
        chk("gap_done", 96'(dcnt), 96'd1);
        if (q.size() == 24) chk_frame("gap", 0);

        clr();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'hFF);
        idle(2);
        chk("pre_fs_none", 96'({q.size(), dcnt}), 96'd0);
        send_frame(0, 1'b0);
        idle(3);
        chk("pre_fs_count", 96'(q.size()), 96'd24);
        chk("pre_fs_done", 96'(dcnt), 96'd1);
        if (q.size() == 24) chk_frame("pre_fs", 0);

        clr();
        pmode = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (y < 3 || (y == 3 && x < 3))
                    send_px(x, y, 0, (x == 0 && y == 0));
        chk("abort_count", 96'(q.size()), 96'd7);
        if (q.size() == 7)
            chk("abort_last", 96'({q[6].cx, q[6].cy}),
                96'({CW'(1), CW'(2)}));
        send_frame(0, 1'b0);
        idle(3);
        chk("abort_total", 96'(q.size()), 96'd31);
        chk("abort_done", 96'(dcnt), 96'd1);
        if (q.size() == 31) chk_frame("restart", 7);

        clr();
        pmode = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                if (y < 2 || x < 5)
                    send_px(x, y, 0, (x == 0 && y == 0));
        rst = 1'b1;
        send_px(5, 2, 0, 1'b0);
        rst = 1'b0;
        chk("rst_outputs",
            96'({filter_input_0, filter_input_1, filter_input_2,
                 window_valid, center_x, center_y, frame_done}), 96'd0);
        chk("rst_pre_count", 96'(q.size()), 96'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hAA);
        idle(1);
        chk("rst_idle_none", 96'({q.size(), dcnt}), 96'(3 << 32));
        send_frame(0, 1'b0);
        idle(3);
        chk("rst_count", 96'(q.size()), 96'd27);
        chk("rst_done", 96'(dcnt), 96'd1);
        if (q.size() == 27) chk_frame("rst", 3);

        clr();
        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        idle(3);
        chk("b2b_count", 96'(q.size()), 96'd48);
        chk("b2b_done", 96'(dcnt), 96'd2);
        if (q.size() == 48) begin
            chk_frame("b2b_f1", 0);
            chk("b2b_f2_first",
                96'({q[24].cx, q[24].cy, q[24].rows}),
                96'({CW'(1), CW'(1), 72'hFDFEFF_EDEEEF_DDDEDF}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypoint_window_gen.md
# keypoint_window_gen

Streaming 3x3 window generator that sits directly upstream of the keypoint filter. It accepts one 8-bit grey pixel per cycle in raster order and buffers the two previous image lines. For every interior pixel it presents the 3x3 neighbourhood as three packed 24-bit rows, in exactly the layout the keypoint filter consumes. It also tags each window with its centre coordinates and flags end of frame.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 3)
- IMG_HEIGHT, 480, lines per frame (>= 3)
- COORD_W, 10, width of coordinate outputs; must satisfy 2^COORD_W >= max(IMG_WIDTH, IMG_HEIGHT)
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pixel_in  input  8  pixel value
- pixel_valid  input  1  pixel_in is valid this cycle; no backpressure
- frame_start  input  1  qualifies pixel_valid; marks pixel (0,0) of a frame
- filter_input_0  output  24  top row (y-1): [7:0]=x-1, [15:8]=x, [23:16]=x+1
- filter_input_1  output  24  middle row (y), same column packing
- filter_input_2  output  24  bottom row (y+1), same column packing
- window_valid  output  1  window outputs and coordinates valid this cycle
- center_x  output  COORD_W  column of window centre
- center_y  output  COORD_W  row of window centre
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- FSM states: IDLE, STREAM.
  - IDLE: pixels without frame_start are dropped. A pixel with frame_start is taken as (0,0) and the FSM moves to STREAM.
  - STREAM: each pixel_valid advances col. At col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) returns the FSM to IDLE.
- frame_start with pixel_valid in STREAM restarts the frame: that pixel becomes (0,0), counters are overwritten, and no frame_done is issued for the aborted frame.
- Line buffers:
  - Two IMG_WIDTH x 8 buffers, indexed by col. lb1 holds row-1 and lb0 holds row-2.
  - On each accepted pixel: read lb0[col] and lb1[col], write lb0[col] <= lb1[col] and lb1[col] <= pixel_in.
  - Contents are not reset. Windows are gated by the row count, so stale data never reaches the outputs.
- Column shift: three 3-tap shift registers, one per row (row-2, row-1, current), advance on accepted pixels only.
- Window emission:
  - Condition: an accepted pixel at (col,row) with col >= 2 and row >= 2.
  - Emitted window: centre (col-1, row-1). filter_input_0 is built from the row-2 taps, filter_input_1 from row-1, filter_input_2 from the current row.
  - Newest pixel goes in [23:16], oldest in [7:0].
- Border pixels (row 0, row H-1, col 0, col W-1) never appear as centres. Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Column-shift taps from the previous line are not used at col 0/1. Windows never straddle a line wrap.
- pixel_valid gaps: all state holds and window_valid = 0. The other outputs hold their last values.

## Timing
- Reset value of every output is 0: filter_input_0/1/2, window_valid, center_x, center_y, frame_done. State = IDLE, col = row = 0.
- Reset mid-frame: the next cycle is IDLE with outputs 0, and the partial frame is discarded.
- Latency: all outputs are registered. window_valid rises one cycle after the clock edge that accepts the pixel completing the window.
- Back-to-back pixels produce back-to-back windows, so throughput is 1 window/cycle.
- frame_done:
  - Asserts one cycle after the edge accepting (W-1,H-1).
  - Coincides with window_valid for centre (W-2,H-2).
- frame_start on the cycle after the last pixel is accepted: a new frame starts with no bubble. frame_done for the old frame still pulses.
- Simultaneous frame_start and the last pixel: frame_start wins. The pixel is treated as (0,0) of a new frame and frame_done is not pulsed.

## Test plan
Bench configuration: IMG_WIDTH=8, IMG_HEIGHT=6, pixel(x,y) = y*16+x, continuous pixel_valid unless stated.
- Full frame -> exactly 24 window_valid pulses. First window: centre (1,1), filter_input_0=24'h020100, filter_input_1=24'h121110, filter_input_2=24'h222120. Last window: centre (6,4) = 24'h373635/24'h474645/24'h575655, coincident with the single frame_done pulse.
- pixel_valid toggled 1,0,1,0 through the frame -> same 24 windows with identical values; window_valid never asserts in a gap cycle.
- Pixels before the first frame_start (10 cycles of 8'hFF) -> no windows, no frame_done; the frame after frame_start is identical to the full-frame case.
- frame_start re-asserted at pixel (3,3) -> the windows already emitted for centres (1..6,1) and (1,2) stand, later windows from the aborted frame are not produced, and no frame_done is issued for it. The restarted full frame gives 24 correct windows and one frame_done.
- rst held for 1 cycle at pixel (5,2) -> all outputs 0 on the following cycle, FSM in IDLE. The next frame is correct with no stale data in its windows.
- Two frames back-to-back, the second with pixel = 8'hFF - (y*16+x) -> 48 windows total and two frame_done pulses; first window of frame 2 is 24'hFDFEFF/24'hEDEEEF/24'hDDDEDF.
